z80_inc16_seq: RTL and testbench

//  Sequencer for 16-bit INC/DEC rr (BC/DE/HL/SP/IX/IY) on the core's shared 8-bit adder.

---
 rtl/z80_inc16_pkg.sv | 27 ++
 rtl/z80_inc16_byte_op.sv | 16 +
 rtl/z80_inc16_seq.sv | 139 +++++++++++++
 tb/tb_z80_inc16_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_inc16_pkg.sv
// Shared types for the 16-bit INC/DEC rr sequencer: FSM states, register-pair selects.
// Select codes above RR_IY are illegal and complete with err instead of a write.
package z80_inc16_pkg;

  localparam int RR_SEL_W = 3;

  typedef logic [RR_SEL_W-1:0] rr_sel_t;

  localparam rr_sel_t RR_BC = 3'd0;
  localparam rr_sel_t RR_DE = 3'd1;
  localparam rr_sel_t RR_HL = 3'd2;
  localparam rr_sel_t RR_SP = 3'd3;
  localparam rr_sel_t RR_IX = 3'd4;
  localparam rr_sel_t RR_IY = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    WB   = 2'd3
  } inc16_state_t;

  function automatic logic rr_sel_legal(input rr_sel_t sel);
    return (sel <= RR_IY);
  endfunction

endpackage

// File: rtl/z80_inc16_byte_op.sv
// Operand B / carry-in for one byte pass: +1 is 01 then 00+carry, -1 is FF then FF+carry.
// Purely combinational, no state, no handshake.
module z80_inc16_byte_op (
  input  logic       dec,
  input  logic       hi_phase,
  input  logic       c,
  output logic [7:0] alu_b,
  output logic       alu_cin
);

  always_comb begin
    alu_b   = dec ? 8'hFF : (hi_phase ? 8'h00 : 8'h01);
    alu_cin = hi_phase & c;
  end

endmodule

// File: rtl/z80_inc16_seq.sv
// INC/DEC rr sequencer on the shared 8-bit adder: write strobe 3 cycles after transfer with steady grant,
// stalls while alu_gnt is low, accepts only in IDLE. Z80_INC16_FI_EN adds the fi_* retirement ports.
module z80_inc16_seq
  import z80_inc16_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_dec,
  input  logic [RR_SEL_W-1:0] req_sel,
  output logic [RR_SEL_W-1:0] rf_rd_sel,
  input  logic [15:0]         rf_rd_data,
  output logic                rf_wr_en,
  output logic [RR_SEL_W-1:0] rf_wr_sel,
  output logic [15:0]         rf_wr_data,
  output logic                alu_req,
  input  logic                alu_gnt,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_cin,
  input  logic [7:0]          alu_y,
  input  logic                alu_cout,
  output logic                done,
  output logic                err
`ifdef Z80_INC16_FI_EN
  ,
  output logic                fi_valid,
  output logic [RR_SEL_W-1:0] fi_sel,
  output logic [15:0]         fi_rr_in,
  output logic [15:0]         fi_rr_out
`endif
);

  inc16_state_t state_q, state_d;

  logic [15:0]   op_q;
  rr_sel_t       sel_q;
  logic          dec_q;
  logic          err_q;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic          c_q;

  logic          xfer;
  logic          hi_phase;
  logic [7:0]    op_b;
  logic          op_cin;

  assign xfer      = req_valid && req_ready;
  assign rf_rd_sel = req_sel;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    alu_req   = 1'b0;
    hi_phase  = 1'b0;
    rf_wr_en  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = rr_sel_legal(req_sel) ? LO : WB;
        end
      end
      LO: begin
        alu_req = 1'b1;
        if (alu_gnt) state_d = HI;
      end
      HI: begin
        alu_req  = 1'b1;
        hi_phase = 1'b1;
        if (alu_gnt) state_d = WB;
      end
      WB: begin
        rf_wr_en = !err_q;
        done     = 1'b1;
        err      = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sel_q   <= RR_BC;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        op_q  <= rf_rd_data;
        sel_q <= req_sel;
        dec_q <= req_dec;
        err_q <= !rr_sel_legal(req_sel);
      end
      if (state_q == LO && alu_gnt) begin
        lo_q <= alu_y;
        c_q  <= alu_cout;
      end
      // High-byte carry-out is dropped: the pair wraps modulo 2^16.
      if (state_q == HI && alu_gnt) begin
        hi_q <= alu_y;
      end
    end
  end

  z80_inc16_byte_op u_byte_op (
    .dec      (dec_q),
    .hi_phase (hi_phase),
    .c        (c_q),
    .alu_b    (op_b),
    .alu_cin  (op_cin)
  );

  // Operands are forced to zero when the adder is not requested.
  assign alu_a   = alu_req ? (hi_phase ? op_q[15:8] : op_q[7:0]) : 8'h00;
  assign alu_b   = alu_req ? op_b : 8'h00;
  assign alu_cin = alu_req & op_cin;

  assign rf_wr_sel  = sel_q;
  assign rf_wr_data = {hi_q, lo_q};

`ifdef Z80_INC16_FI_EN
  assign fi_valid  = done && !err_q;
  assign fi_sel    = sel_q;
  assign fi_rr_in  = op_q;
  assign fi_rr_out = {hi_q, lo_q};
`endif

endmodule

// File: tb/tb_z80_inc16_seq.sv
// Directed bench for z80_inc16_seq with a behavioural register file and 8-bit adder.
module tb_z80_inc16_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_dec;
  logic [2:0]  req_sel;
  logic [2:0]  rf_rd_sel;
  logic [15:0] rf_rd_data;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_sel;
  logic [15:0] rf_wr_data;
  logic        alu_req;
  logic        alu_gnt;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_y;
  logic        alu_cout;
  logic        done;
  logic        err;
`ifdef Z80_INC16_FI_EN
  logic        fi_valid;
  logic [2:0]  fi_sel;
  logic [15:0] fi_rr_in;
  logic [15:0] fi_rr_out;
`endif

  logic [15:0] rf [0:7];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rf_rd_data        = rf[rf_rd_sel];
  assign {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};

  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_sel] <= rf_wr_data;
  end

  z80_inc16_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dec    (req_dec),
    .req_sel    (req_sel),
    .rf_rd_sel  (rf_rd_sel),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_sel  (rf_wr_sel),
    .rf_wr_data (rf_wr_data),
    .alu_req    (alu_req),
    .alu_gnt    (alu_gnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_y      (alu_y),
    .alu_cout   (alu_cout),
    .done       (done),
    .err        (err)
`ifdef Z80_INC16_FI_EN
    ,
    .fi_valid   (fi_valid),
    .fi_sel     (fi_sel),
    .fi_rr_in   (fi_rr_in),
    .fi_rr_out  (fi_rr_out)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request at cycle 0 and follows it to done; gmask bit k is alu_gnt in cycle k.
  task automatic run_op(input logic [2:0] sel, input logic dec, input logic [15:0] gmask,
                        output logic xfer_ok, output int done_cyc, output logic [15:0] wdata,
                        output logic [2:0] wsel, output logic err_o, output int wen_cnt);
    done_cyc = -1;
    wen_cnt  = 0;
    wdata    = 16'hxxxx;
    wsel     = 3'bxxx;
    err_o    = 1'bx;
    req_sel   = sel;
    req_dec   = dec;
    req_valid = 1'b1;
    alu_gnt   = gmask[0];
    #1;
    xfer_ok = req_ready;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 20; c++) begin
      alu_gnt = gmask[c % 16];
      #1;
      if (rf_wr_en) wen_cnt++;
      if (done) begin
        done_cyc = c;
        wdata    = rf_wr_data;
        wsel     = rf_wr_sel;
        err_o    = err;
        break;
      end
      tick();
    end
    tick();
    alu_gnt = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_dec = 1'b0; req_sel = 3'd0; alu_gnt = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    tick(); tick();
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    n_chk++; if ({rf_wr_en, alu_req, done, err} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_strobes got wr/req/done/err=%b exp=0000", {rf_wr_en, alu_req, done, err}); end
    n_chk++; if ({alu_a, alu_b, alu_cin} !== 17'h0) begin n_fail++;
      $display("FAIL reset_alu_ops got a=%h b=%h cin=%b exp=0", alu_a, alu_b, alu_cin); end
    n_chk++; if (rf_wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_result got=%h exp=0000", rf_wr_data); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_inc_hl();
    logic ok; int dc; logic [15:0] wd; logic [2:0] ws; logic e; int wc;
    rf[2] = 16'h00FF;
    run_op(3'd2, 1'b0, 16'hFFFF, ok, dc, wd, ws, e, wc);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inc_hl_accept got=%b exp=1", ok); end
    n_chk++; if (dc != 3) begin n_fail++; $display("FAIL inc_hl_latency got=%0d exp=3", dc); end
    n_chk++; if (wd !== 16'h0100) begin n_fail++; $display("FAIL inc_hl_data got=%h exp=0100", wd); end
    n_chk++; if (ws !== 3'd2) begin n_fail++; $display("FAIL inc_hl_sel got=%0d exp=2", ws); end
    n_chk++; if (e !== 1'b0 || wc != 1) begin n_fail++; $display("FAIL inc_hl_wr got err=%b wen=%0d exp err=0 wen=1", e, wc); end
    n_chk++; if (rf[2] !== 16'h0100) begin n_fail++; $display("FAIL inc_hl_rf got=%h exp=0100", rf[2]); end
  endtask

  task automatic test_alu_operands();
    rf[1] = 16'h12FF;
    req_sel = 3'd1; req_dec = 1'b0; req_valid = 1'b1; alu_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    n_chk++; if ({alu_req, alu_a, alu_b, alu_cin} !== {1'b1, 8'hFF, 8'h01, 1'b0}) begin n_fail++;
      $display("FAIL lo_ops got req=%b a=%h b=%h cin=%b exp 1 FF 01 0", alu_req, alu_a, alu_b, alu_cin); end
    tick();
    n_chk++; if ({alu_req, alu_a, alu_b, alu_cin} !== {1'b1, 8'h12, 8'h00, 1'b1}) begin n_fail++;
      $display("FAIL hi_ops got req=%b a=%h b=%h cin=%b exp 1 12 00 1", alu_req, alu_a, alu_b, alu_cin); end
    tick();
    n_chk++; if ({rf_wr_en, rf_wr_data, alu_req, alu_a} !== {1'b1, 16'h1300, 1'b0, 8'h00}) begin n_fail++;
      $display("FAIL wb_inc_de got wen=%b data=%h req=%b a=%h exp 1 1300 0 00", rf_wr_en, rf_wr_data, alu_req, alu_a); end
    tick();
  endtask

  task automatic test_dec_ixiy();
    logic ok; int dc; logic [15:0] wd; logic [2:0] ws; logic e; int wc;
    rf[4] = 16'h0000; rf[5] = 16'h0100;
    run_op(3'd4, 1'b1, 16'hFFFF, ok, dc, wd, ws, e, wc);
    n_chk++; if (wd !== 16'hFFFF || ws !== 3'd4) begin n_fail++; $display("FAIL dec_ix got data=%h sel=%0d exp FFFF 4", wd, ws); end
    n_chk++; if (rf[5] !== 16'h0100) begin n_fail++; $display("FAIL dec_ix_iy_untouched got=%h exp=0100", rf[5]); end
    run_op(3'd5, 1'b1, 16'hFFFF, ok, dc, wd, ws, e, wc);
    n_chk++; if (wd !== 16'h00FF || ws !== 3'd5) begin n_fail++; $display("FAIL dec_iy got data=%h sel=%0d exp 00FF 5", wd, ws); end
    n_chk++; if (rf[4] !== 16'hFFFF || rf[5] !== 16'h00FF) begin n_fail++;
      $display("FAIL dec_ixiy_rf got ix=%h iy=%h exp FFFF 00FF", rf[4], rf[5]); end
  endtask

  task automatic test_stall_sp();
    logic ok; int dc; logic [15:0] wd; logic [2:0] ws; logic e; int wc;
    rf[3] = 16'hFFFF;
    // grant low in cycles 1,2 (LO) and 4 (HI)
    run_op(3'd3, 1'b0, 16'hFFE9, ok, dc, wd, ws, e, wc);
    n_chk++; if (dc != 6) begin n_fail++; $display("FAIL stall_sp_latency got=%0d exp=6", dc); end
    n_chk++; if (wd !== 16'h0000 || wc != 1) begin n_fail++; $display("FAIL stall_sp_data got=%h wen=%0d exp 0000 1", wd, wc); end
    n_chk++; if (rf[3] !== 16'h0000) begin n_fail++; $display("FAIL stall_sp_rf got=%h exp=0000", rf[3]); end
  endtask

  task automatic test_illegal();
    logic ok; int dc; logic [15:0] wd; logic [2:0] ws; logic e; int wc;
    logic [15:0] r0_exp;
    rf[7] = 16'h5A5A;
    run_op(3'd7, 1'b0, 16'hFFFF, ok, dc, wd, ws, e, wc);
    n_chk++; if (dc != 1 || e !== 1'b1) begin n_fail++; $display("FAIL illegal_done got cyc=%0d err=%b exp 1 1", dc, e); end
    n_chk++; if (wc != 0 || rf[7] !== 16'h5A5A) begin n_fail++; $display("FAIL illegal_nowrite got wen=%0d rf7=%h exp 0 5A5A", wc, rf[7]); end
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready_after got=%b exp=1", req_ready); end
    r0_exp = rf[0] + 16'h0001;
    run_op(3'd0, 1'b0, 16'hFFFF, ok, dc, wd, ws, e, wc);
    n_chk++; if (ok !== 1'b1 || dc != 3 || wd !== r0_exp || e !== 1'b0) begin n_fail++;
      $display("FAIL illegal_next_req got ok=%b cyc=%0d data=%h err=%b exp 1 3 %h 0", ok, dc, wd, e, r0_exp); end
  endtask

  task automatic test_reset_mid();
    int wc;
    wc = 0;
    rf[1] = 16'h1234;
    req_sel = 3'd1; req_dec = 1'b0; req_valid = 1'b1; alu_gnt = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    if (rf_wr_en || done) wc++;
    n_chk++; if (wc != 0) begin n_fail++; $display("FAIL rst_mid_nowb got wen=%b done=%b exp 0 0", rf_wr_en, done); end
    n_chk++; if (req_ready !== 1'b1 || alu_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_idle got ready=%b req=%b exp 1 0", req_ready, alu_req); end
    reset_n = 1'b1;
    tick(); tick();
    n_chk++; if (rf[1] !== 16'h1234) begin n_fail++; $display("FAIL rst_mid_rf got=%h exp=1234", rf[1]); end
  endtask

  task automatic test_back_to_back();
    int xc [$];
    rf[0] = 16'h0000;
    req_sel = 3'd0; req_dec = 1'b0; req_valid = 1'b1; alu_gnt = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (req_valid && req_ready) xc.push_back(c);
      tick();
    end
    req_valid = 1'b0;
    tick();
    n_chk++; if (xc.size() != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", xc.size()); end
    else begin
      n_chk++; if (xc[0] != 0 || xc[1] != 4) begin n_fail++; $display("FAIL b2b_cycles got=%0d,%0d exp=0,4", xc[0], xc[1]); end
    end
    n_chk++; if (rf[0] !== 16'h0002) begin n_fail++; $display("FAIL b2b_rf got=%h exp=0002", rf[0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_inc_hl();
    test_alu_operands();
    test_dec_ixiy();
    test_stall_sp();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
